// File: rtl/memb_pkg.sv
// Shared definitions for the MemB read streamer: FSM state encoding and skid-buffer sizing.
package memb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/memb_read_streamer_if.sv
// RAM read port and output stream of the MemB read streamer.
// Optional out_last signal is present when STREAM_LAST_EN is defined.
interface memb_read_streamer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef STREAM_LAST_EN
  logic              out_last;
`endif

  // Stream handshake: a word moves when out_valid & out_ready are both high on a
  // rising edge; once out_valid is raised, out_valid/out_data stay stable until taken.
  modport master (
    output rd_en, rd_addr, out_valid, out_data,
`ifdef STREAM_LAST_EN
    out_last,
`endif
    input  rd_data, out_ready
  );

  modport slave (
    input  rd_en, rd_addr, out_valid, out_data,
`ifdef STREAM_LAST_EN
    out_last,
`endif
    output rd_data, out_ready
  );

endinterface

// File: rtl/memb_skid_buf.sv
// Two-entry FIFO that absorbs RAM read data while the consumer stalls.
module memb_skid_buf
  import memb_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic [W-1:0]     head
);

  logic [W-1:0] mem [SKID_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/memb_read_streamer.sv
// Drains DEPTH words from the MemB synchronous-read RAM onto a valid/ready stream.
// Define STREAM_LAST_EN to add out_last, flagging the word from address DEPTH-1.
module memb_read_streamer
  import memb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int DEPTH  = 4
) (
  input  logic   clk,
  input  logic   Reset,
  input  logic   start,
  output logic   busy,
  output logic   done,
  output state_t dbg_state,
  memb_read_streamer_if.master bus
);

`ifdef STREAM_LAST_EN
  localparam int BW = DATA_W + 1;
`else
  localparam int BW = DATA_W;
`endif
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt;
  logic              inflight;
  logic              issue;
  logic              pop;
  logic [OCC_W-1:0]  occ;
  logic [2:0]        committed;
  logic [BW-1:0]     push_word;
  logic [BW-1:0]     head;

  // Words buffered or in flight that will still be held after this cycle's pop.
  always_comb committed = 3'(occ) + 3'(inflight) - 3'(pop);

  assign pop   = bus.out_valid & bus.out_ready;
  assign issue = (state == ST_FETCH) && (committed < 3'd2);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_FETCH;
      ST_FETCH: if (issue && cnt == LAST_IDX) state_nxt = ST_DRAIN;
      // Leave as the last word is taken so done lands right after it.
      ST_DRAIN: if (!inflight && (occ == '0 || (occ == OCC_W'(1) && pop)))
                  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (state == ST_IDLE) cnt <= '0;
      else if (issue)       cnt <= cnt + (ADDR_W + 1)'(1);
    end
  end

`ifdef STREAM_LAST_EN
  logic inflight_last;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) inflight_last <= 1'b0;
    else       inflight_last <= issue && (cnt == LAST_IDX);
  end

  assign push_word    = {inflight_last, bus.rd_data};
  assign bus.out_last = bus.out_valid & head[DATA_W];
`else
  assign push_word = bus.rd_data;
`endif

  memb_skid_buf #(.W(BW)) u_skid (
    .clk   (clk),
    .Reset (Reset),
    .push  (inflight),
    .din   (push_word),
    .pop   (pop),
    .occ   (occ),
    .head  (head)
  );

  assign bus.out_valid = (occ != '0);
  assign bus.out_data  = bus.out_valid ? head[DATA_W-1:0] : '0;
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = issue ? cnt[ADDR_W-1:0] : '0;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_memb_read_streamer.sv
// Scoreboard bench for memb_read_streamer: RAM model, randomized backpressure, reset mid-run.
module tb_memb_read_streamer;
  import memb_pkg::*;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic   clk = 1'b0;
  logic   Reset;
  logic   start;
  logic   busy;
  logic   done;
  state_t dbg_state;

  memb_read_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  memb_read_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- synchronous-read RAM model ----------------
  logic [DATA_W-1:0] ram [2**ADDR_W];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];
  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!Reset && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_word @%0t: got %0h, expected no word", $time, bus.out_data);
      end else begin
        check("out_data", bus.out_data, exp_q[0][DATA_W-1:0]);
`ifdef STREAM_LAST_EN
        check("out_last", bus.out_last, exp_q[0][DATA_W]);
`endif
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // mode: 0 ready=1, 1 toggle 1,0,.., 2 random, 3 ready=1 with extra start pulses,
  //       4 ready low in cycles 3..8
  task automatic load_ram(input bit fixed_data);
    for (int i = 0; i < 2**ADDR_W; i++)
      ram[i] = fixed_data ? DATA_W'(8'hA1 + i * 8'h11) : DATA_W'($urandom_range(0, 255));
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({(i == DEPTH - 1), ram[i]});
  endtask

  task automatic run(input int mode, input bit fixed_data);
    int issued = 0;
    int delivered = 0;
    int done_cnt = 0;
    bit finished = 1'b0;
    bit pop;
    bit exp_rd_en;
    load_ram(fixed_data);
    @(posedge clk); #1;
    start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 300 && !finished; c++) begin
      @(posedge clk); #1;
      start = (mode == 3) && (c == 2 || c == 5);
      case (mode)
        1:       bus.out_ready = c[0];
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        4:       bus.out_ready = !(c >= 3 && c <= 8);
        default: bus.out_ready = 1'b1;
      endcase
      @(negedge clk);
      pop = bus.out_valid && bus.out_ready;
      exp_rd_en = busy && (issued < DEPTH) && (issued - delivered - int'(pop) < 2);
      check("rd_en", bus.rd_en, exp_rd_en);
      if (bus.rd_en) begin
        check("rd_addr", bus.rd_addr, issued);
        issued++;
      end
      if (pop)  delivered++;
      if (done) done_cnt++;
      if (mode == 0 && fixed_data) begin
        check("busy_timing", busy, (c <= DEPTH + 3));
        check("valid_timing", bus.out_valid, (c >= 3 && c <= DEPTH + 2));
        check("done_timing", done, (c == DEPTH + 3));
      end
      if (mode == 4 && c == 8) check("stall_issue", issued, 2);
      if (!busy) finished = 1'b1;
    end
    if (!finished) begin
      vectors++;
      errors++;
      $display("FAIL run_timeout mode %0d: got busy after 300 cycles, expected idle", mode);
    end
    check("issued", issued, DEPTH);
    check("delivered", delivered, DEPTH);
    check("done_count", done_cnt, 1);
    check("leftover", exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_rd_en"},     bus.rd_en, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_rd_addr"},   bus.rd_addr, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
`ifdef STREAM_LAST_EN
    check({tag, "_out_last"},  bus.out_last, 0);
`endif
  endtask

  task automatic reset_mid_run();
    load_ram(1'b1);
    @(posedge clk); #1;
    start = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 4) begin
        Reset = 1'b1;
        exp_q.delete();
      end
      @(negedge clk);
    end
    check_outputs_zero("midreset");
    @(posedge clk); #1;
    Reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Reset = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    check("reset_state", dbg_state, ST_IDLE);
    @(posedge clk); #1;
    Reset = 1'b0;

    run(0, 1'b1);
    run(4, 1'b1);
    run(1, 1'b0);
    run(3, 1'b0);
    run(0, 1'b0);
    reset_mid_run();
    run(0, 1'b1);
    for (int r = 0; r < 6; r++) run((r % 3 == 2) ? 4 : $urandom_range(1, 2), 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
